regbank_access_sequencer: RTL and testbench

- Sole owner of the single-port 16x32 register bank (one regNum, one dataIn, one dataOut, one writeEnable).
- Shares that port between three requesters:
  - core operand fetch: two reads per request;
  - core writeback: one write;
  - debug port: one read or write.
- Serialises accesses with a small FSM and a fixed-priority arbiter that includes a starvation guard for debug.
- Sits between the CPU control unit and the register bank.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/regbank_access_sequencer_if.sv | 46 ++++
 rtl/regbank_arbiter.sv | 42 ++++
 rtl/regbank_access_sequencer.sv | 120 ++++++++++++
 tb/tb_regbank_access_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-bank access FSM encoding and arbiter grant indices.
//   DATA_WIDTH / REG_ADDR_W : register data and index widths (16x32 bank)
//   ZERO_REG                : hard-wired zero register, never written
//   state_t                 : sequencer FSM states
//   GNT_*                   : bit positions of the one-hot arbiter grant
package cpu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [REG_ADDR_W-1:0] reg_t;

    localparam reg_t ZERO_REG = '0;

    typedef enum logic [2:0] {IDLE, READ_A, READ_B, WRITE, DEBUG} state_t;

    localparam int GNT_WB  = 0;
    localparam int GNT_RD  = 1;
    localparam int GNT_DBG = 2;
endpackage

// File: rtl/regbank_access_sequencer_if.sv
// regbank_access_sequencer_if: requester handshakes and register-bank port bundle.
//   operand fetch : rd_req_valid/ready, rd_rs1, rd_rs2 -> op_valid, op_a, op_b
//   writeback     : wb_valid/ready, wb_rd, wb_data
//   debug         : dbg_valid/ready, dbg_we, dbg_reg, dbg_wdata -> dbg_rvalid, dbg_rdata
//   bank port     : bank_regNum, bank_dataIn, bank_we -> bank_dataOut
//   slave  modport: the sequencer; master modport: control unit / bank side
interface regbank_access_sequencer_if
    import cpu_pkg::*;
;
    logic  rd_req_valid;
    logic  rd_req_ready;
    reg_t  rd_rs1;
    reg_t  rd_rs2;
    logic  op_valid;
    data_t op_a;
    data_t op_b;
    logic  wb_valid;
    logic  wb_ready;
    reg_t  wb_rd;
    data_t wb_data;
    logic  dbg_valid;
    logic  dbg_ready;
    logic  dbg_we;
    reg_t  dbg_reg;
    data_t dbg_wdata;
    logic  dbg_rvalid;
    data_t dbg_rdata;
    reg_t  bank_regNum;
    data_t bank_dataIn;
    logic  bank_we;
    data_t bank_dataOut;

    modport slave (
        input  rd_req_valid, rd_rs1, rd_rs2, wb_valid, wb_rd, wb_data,
               dbg_valid, dbg_we, dbg_reg, dbg_wdata, bank_dataOut,
        output rd_req_ready, op_valid, op_a, op_b, wb_ready, dbg_ready,
               dbg_rvalid, dbg_rdata, bank_regNum, bank_dataIn, bank_we
    );

    modport master (
        output rd_req_valid, rd_rs1, rd_rs2, wb_valid, wb_rd, wb_data,
               dbg_valid, dbg_we, dbg_reg, dbg_wdata, bank_dataOut,
        input  rd_req_ready, op_valid, op_a, op_b, wb_ready, dbg_ready,
               dbg_rvalid, dbg_rdata, bank_regNum, bank_dataIn, bank_we
    );
endinterface

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: fixed-priority 3-way arbiter with a debug starvation guard.
//   clk, reset (async, active-low)
//   idle       : sequencer can accept a request this cycle
//   wb_valid, rd_valid, dbg_valid : requests
//   grant      : one-hot, indexed by GNT_WB / GNT_RD / GNT_DBG
// Priority: starved debug, then writeback, then fetch, then debug.
module regbank_arbiter
    import cpu_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle,
    input  logic       wb_valid,
    input  logic       rd_valid,
    input  logic       dbg_valid,
    output logic [2:0] grant
);
    localparam int CW = $clog2(DBG_MAX_WAIT + 1);

    logic [CW-1:0] starve;
    logic          starved;

    assign starved = starve == CW'(DBG_MAX_WAIT);

    always_comb begin
        grant = '0;
        if (idle) begin
            if (dbg_valid && starved) grant[GNT_DBG] = 1'b1;
            else if (wb_valid)        grant[GNT_WB]  = 1'b1;
            else if (rd_valid)        grant[GNT_RD]  = 1'b1;
            else if (dbg_valid)       grant[GNT_DBG] = 1'b1;
        end
    end

    // Only IDLE cycles count: while busy every requester is simply holding.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve <= '0;
        else if (idle) starve <= (!dbg_valid || grant[GNT_DBG]) ? '0 : starved ? starve : starve + 1'b1;
    end
endmodule

// File: rtl/regbank_access_sequencer.sv
// regbank_access_sequencer: sole owner of the single-port 16x32 register bank,
// serialising operand fetch (two reads), writeback (one write) and debug access.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : regbank_access_sequencer_if.slave (requester handshakes + bank port)
// One access is in flight at a time, so a read accepted after a write always
// observes the written value.
module regbank_access_sequencer
    import cpu_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    regbank_access_sequencer_if.slave bus
);
    state_t     state, state_nx;
    reg_t       ra, rb;
    data_t      wdata;
    logic       dwe;
    logic [2:0] grant;
    logic       idle;
    logic       wr;
    reg_t       regnum;
    data_t      datain;
    logic       we;
    logic       op_v, dbg_v;
    data_t      op_a, op_b, dbg_rd;

    // Readies are held low while reset is asserted even though the FSM sits in IDLE.
    assign idle = reset && state == IDLE;

    regbank_arbiter #(.DBG_MAX_WAIT(DBG_MAX_WAIT)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .idle      (idle),
        .wb_valid  (bus.wb_valid),
        .rd_valid  (bus.rd_req_valid),
        .dbg_valid (bus.dbg_valid),
        .grant     (grant)
    );

    assign bus.wb_ready     = grant[GNT_WB];
    assign bus.rd_req_ready = grant[GNT_RD];
    assign bus.dbg_ready    = grant[GNT_DBG];
    assign bus.bank_regNum  = regnum;
    assign bus.bank_dataIn  = datain;
    assign bus.bank_we      = we;
    assign bus.op_valid     = op_v;
    assign bus.op_a         = op_a;
    assign bus.op_b         = op_b;
    assign bus.dbg_rvalid   = dbg_v;
    assign bus.dbg_rdata    = dbg_rd;

    // ra is shared: rs1 for fetches, destination for writeback and debug.
    assign wr = state == WRITE || (state == DEBUG && dwe);

    always_comb begin
        state_nx = state;
        regnum   = '0;
        datain   = '0;
        we       = 1'b0;
        case (state)
            IDLE: state_nx = grant[GNT_WB] ? WRITE : grant[GNT_RD] ? READ_A : grant[GNT_DBG] ? DEBUG : IDLE;
            READ_A: begin
                regnum   = ra;
                state_nx = ra == rb ? IDLE : READ_B;
            end
            READ_B: begin
                regnum   = rb;
                state_nx = IDLE;
            end
            WRITE, DEBUG: begin
                regnum   = ra;
                datain   = wr ? wdata : '0;
                we       = wr && ra != ZERO_REG;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            wdata  <= '0;
            dwe    <= 1'b0;
            op_v   <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            dbg_v  <= 1'b0;
            dbg_rd <= '0;
        end else begin
            state <= state_nx;
            op_v  <= (state == READ_A && ra == rb) || state == READ_B;
            dbg_v <= state == DEBUG && !dwe;
            if (grant[GNT_RD]) begin
                ra <= bus.rd_rs1;
                rb <= bus.rd_rs2;
            end
            if (grant[GNT_WB]) begin
                ra    <= bus.wb_rd;
                wdata <= bus.wb_data;
            end
            if (grant[GNT_DBG]) begin
                ra    <= bus.dbg_reg;
                wdata <= bus.dbg_wdata;
                dwe   <= bus.dbg_we;
            end
            if (state == READ_A) begin
                op_a <= bus.bank_dataOut;
                if (ra == rb) op_b <= bus.bank_dataOut;
            end
            if (state == READ_B) op_b <= bus.bank_dataOut;
            if (state == DEBUG && !dwe) dbg_rd <= bus.bank_dataOut;
        end
    end
endmodule

// File: tb/tb_regbank_access_sequencer.sv
// tb_regbank_access_sequencer: directed stimulus against a transaction-level model
// (planned bank-port slots, reference register file, debug wait counter).
module tb_regbank_access_sequencer;
    import cpu_pkg::*;

    localparam int MAXW = 8;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
        logic        we;
    } slot_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int cyc = 0;
    int total = 0;
    int passed = 0;

    regbank_access_sequencer_if bus();

    regbank_access_sequencer #(.DBG_MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] bank [16] = '{default: '0};
    always @(posedge clk) if (bus.bank_we) bank[bus.bank_regNum] <= bus.bank_dataIn;
    assign bus.bank_dataOut = bank[bus.bank_regNum];

    logic we_x0 = 1'b0;
    always @(negedge clk) if (bus.bank_we && bus.bank_regNum == 4'd0) we_x0 = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- model ----------------
    slot_t       plan[$];
    slot_t       s;
    logic [2:0]  g;
    logic [31:0] ref_regs [16] = '{default: '0};
    int          starve_m = 0;
    int          op_due = -1;
    int          dbg_due = -1;
    logic [31:0] exp_a, exp_b, exp_d;

    always @(negedge clk) begin
        if (!reset) begin
            plan.delete();
            starve_m = 0;
            op_due = -1;
            dbg_due = -1;
            chk("rst_readies", {bus.rd_req_ready, bus.wb_ready, bus.dbg_ready}, 0);
            chk("rst_pulses", {bus.op_valid, bus.dbg_rvalid}, 0);
            chk("rst_data", bus.op_a | bus.op_b | bus.dbg_rdata, 0);
            chk("rst_bank", {bus.bank_regNum, bus.bank_dataIn, bus.bank_we}, 0);
        end else begin
            s = '{r: '0, d: '0, we: 1'b0};
            g = '0;
            if (plan.size() > 0) s = plan.pop_front();
            else begin
                if (bus.dbg_valid && starve_m == MAXW) g = 3'b100;
                else if (bus.wb_valid) g = 3'b001;
                else if (bus.rd_req_valid) g = 3'b010;
                else if (bus.dbg_valid) g = 3'b100;
                if (!bus.dbg_valid || g == 3'b100) starve_m = 0;
                else if (starve_m < MAXW) starve_m++;
            end
            chk("readies", {bus.dbg_ready, bus.rd_req_ready, bus.wb_ready}, g);
            chk("bank_port", {bus.bank_regNum, bus.bank_dataIn, bus.bank_we}, {s.r, s.d, s.we});
            chk("op_valid", bus.op_valid, cyc == op_due);
            if (cyc == op_due) begin
                chk("op_a", bus.op_a, exp_a);
                chk("op_b", bus.op_b, exp_b);
            end
            chk("dbg_rvalid", bus.dbg_rvalid, cyc == dbg_due);
            if (cyc == dbg_due) chk("dbg_rdata", bus.dbg_rdata, exp_d);
            if (g[0]) begin
                plan.push_back('{r: bus.wb_rd, d: bus.wb_data, we: bus.wb_rd != 4'd0});
                if (bus.wb_rd != 4'd0) ref_regs[bus.wb_rd] = bus.wb_data;
            end
            if (g[1]) begin
                plan.push_back('{r: bus.rd_rs1, d: '0, we: 1'b0});
                if (bus.rd_rs1 != bus.rd_rs2) plan.push_back('{r: bus.rd_rs2, d: '0, we: 1'b0});
                op_due = cyc + 1 + plan.size();
                exp_a = ref_regs[bus.rd_rs1];
                exp_b = ref_regs[bus.rd_rs2];
            end
            if (g[2]) begin
                if (bus.dbg_we) begin
                    plan.push_back('{r: bus.dbg_reg, d: bus.dbg_wdata, we: bus.dbg_reg != 4'd0});
                    if (bus.dbg_reg != 4'd0) ref_regs[bus.dbg_reg] = bus.dbg_wdata;
                end else begin
                    plan.push_back('{r: bus.dbg_reg, d: '0, we: 1'b0});
                    dbg_due = cyc + 2;
                    exp_d = ref_regs[bus.dbg_reg];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_rdy(input int which, output int gc);
        int i;
        gc = -1;
        for (i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((which == 0 && bus.wb_ready) || (which == 1 && bus.rd_req_ready) || (which == 2 && bus.dbg_ready)) begin
                gc = cyc;
                break;
            end
        end
        chk("handshake_in_time", i < 64, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] r, input logic [31:0] d, output int gc);
        bus.wb_valid = 1'b1;
        bus.wb_rd = r;
        bus.wb_data = d;
        wait_rdy(0, gc);
        bus.wb_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] r1, input logic [3:0] r2, output int gc);
        bus.rd_req_valid = 1'b1;
        bus.rd_rs1 = r1;
        bus.rd_rs2 = r2;
        wait_rdy(1, gc);
        bus.rd_req_valid = 1'b0;
    endtask

    task automatic dbg(input logic w, input logic [3:0] r, input logic [31:0] d, output int gc);
        bus.dbg_valid = 1'b1;
        bus.dbg_we = w;
        bus.dbg_reg = r;
        bus.dbg_wdata = d;
        wait_rdy(2, gc);
        bus.dbg_valid = 1'b0;
    endtask

    task automatic wait_op(output int c, output logic [31:0] a, output logic [31:0] b);
        int i;
        c = -1;
        a = '0;
        b = '0;
        for (i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.op_valid) begin
                c = cyc;
                a = bus.op_a;
                b = bus.op_b;
                break;
            end
        end
        chk("op_valid_in_time", i < 32, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dbg(output int c, output logic [31:0] d);
        int i;
        c = -1;
        d = '0;
        for (i = 0; i < 32; i++) begin
            @(negedge clk);
            if (bus.dbg_rvalid) begin
                c = cyc;
                d = bus.dbg_rdata;
                break;
            end
        end
        chk("dbg_rvalid_in_time", i < 32, 1);
        @(posedge clk);
        #1;
    endtask

    int gw, gr, gd, gx, c, nrd, nop;
    logic [31:0] a, b;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.rd_req_valid = 1'b0;
        bus.rd_rs1 = '0;
        bus.rd_rs2 = '0;
        bus.wb_valid = 1'b0;
        bus.wb_rd = '0;
        bus.wb_data = '0;
        bus.dbg_valid = 1'b0;
        bus.dbg_we = 1'b0;
        bus.dbg_reg = '0;
        bus.dbg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        wb(3, 32'h11, gx);
        wb(5, 32'h22, gx);
        wb(7, 32'hABCD, gx);
        wb(9, 32'h99, gx);
        wb(1, 32'h1001, gx);
        wb(2, 32'h2002, gx);

        rd(3, 5, gr);
        wait_op(c, a, b);
        chk("lat_distinct", c - gr, 3);
        chk("fetch_a_x3", a, 32'h11);
        chk("fetch_b_x5", b, 32'h22);

        rd(7, 7, gr);
        wait_op(c, a, b);
        chk("lat_same", c - gr, 2);
        chk("fetch_a_x7", a, 32'hABCD);
        chk("fetch_b_x7", b, 32'hABCD);

        wb(0, 32'hFFFF, gx);
        rd(0, 0, gr);
        wait_op(c, a, b);
        chk("fetch_x0", a, 0);

        fork
            wb(4, 32'h44, gw);
            rd(4, 3, gr);
            dbg(1'b0, 4, 32'h0, gd);
        join
        chk("order_wb_then_rd", gr - gw, 2);
        chk("order_rd_then_dbg", gd - gr, 3);
        wait_dbg(c, a);
        chk("dbg_lat", c - gd, 2);
        chk("dbg_read_x4", a, 32'h44);

        nrd = 0;
        gd = -1;
        bus.rd_req_valid = 1'b1;
        bus.rd_rs1 = 1;
        bus.rd_rs2 = 2;
        bus.dbg_valid = 1'b1;
        bus.dbg_we = 1'b0;
        bus.dbg_reg = 9;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dbg_ready) begin
                gd = cyc;
                break;
            end
            if (bus.rd_req_ready) nrd++;
        end
        @(posedge clk);
        #1;
        bus.rd_req_valid = 1'b0;
        bus.dbg_valid = 1'b0;
        chk("starve_granted", gd >= 0, 1);
        chk("starve_rd_grants", nrd, MAXW);
        wait_dbg(c, a);
        chk("starve_dbg_x9", a, 32'h99);

        dbg(1'b1, 6, 32'h66, gx);
        dbg(1'b1, 0, 32'h77, gx);
        rd(6, 0, gr);
        wait_op(c, a, b);
        chk("dbg_write_x6", a, 32'h66);
        chk("dbg_write_x0", b, 0);

        rd(3, 5, gr);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_op_a", bus.op_a, 0);
        chk("async_rst_regnum", bus.bank_regNum, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        nop = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.op_valid) nop++;
        end
        @(posedge clk);
        #1;
        chk("no_op_after_rst", nop, 0);
        rd(5, 3, gr);
        wait_op(c, a, b);
        chk("post_rst_lat", c - gr, 3);
        chk("post_rst_a", a, 32'h22);
        chk("post_rst_b", b, 32'h11);

        chk("x0_never_written", we_x0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
